// File: rtl/rvx_dbus_arbiter_pkg.sv
// Shared types and constants for the two-master RVX data bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvx_dbus_arbiter_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int STRB_WIDTH = 4;

    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

    typedef enum logic {
        STATE_IDLE = 1'b0,  // nothing outstanding at the slave
        STATE_BUSY = 1'b1   // one transaction outstanding, owner register valid
    } state_t;

    // One request as seen on the split read/write bus.
    typedef struct packed {
        logic                  rrequest;
        logic                  wrequest;
        logic [BUS_WIDTH-1:0]  address;
        logic [BUS_WIDTH-1:0]  wdata;
        logic [STRB_WIDTH-1:0] wstrobe;
    } bus_req_t;

endpackage

// File: rtl/rvx_dbus_request_holder.sv
// Per-master hold register: parks a request that lost arbitration or met a busy slot.
// Latency: 0 cycles; the held request (or the live one when nothing is held) is visible combinationally.
// Backpressure: a parked request stays until granted; masters never issue a second request meanwhile.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   live         : this cycle's request fields from the master
//   granted      : the arbiter issues this master's candidate this cycle
//   candidate    : a request is pending (live or held)
//   selected     : held request if one is parked, else the live request
module rvx_dbus_request_holder
    import rvx_dbus_arbiter_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  bus_req_t live,
    input  logic     granted,
    output logic     candidate,
    output bus_req_t selected
);

    logic     held_valid;
    bus_req_t held;
    logic     live_valid;

    assign live_valid = live.rrequest | live.wrequest;
    assign candidate  = held_valid | live_valid;
    // A held request is always older than any live one, so it takes precedence.
    assign selected   = held_valid ? held : live;

    always_ff @(posedge clock) begin
        if (reset) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (granted) begin
            held_valid <= 1'b0;
        end else if (live_valid) begin
            held_valid <= 1'b1;
            held       <= live;
        end
    end

endmodule

// File: rtl/rvx_dbus_arbiter.sv
// Two-master, one-slave arbiter for the RVX split read/write bus; one transaction outstanding.
// Latency: 0 added cycles uncontended; a loser issues in the cycle the winner's response returns.
// Backpressure: requests that cannot issue are parked per master until the slot frees.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   m{0,1}_*              : master request pulses/fields in, response pulses and read data out
//   s_*                   : request pulses/fields to the slave, response pulses and read data back
module rvx_dbus_arbiter
    import rvx_dbus_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  m0_address,
    input  logic [BUS_WIDTH-1:0]  m0_wdata,
    input  logic [STRB_WIDTH-1:0] m0_wstrobe,
    input  logic                  m0_rrequest,
    input  logic                  m0_wrequest,
    output logic [BUS_WIDTH-1:0]  m0_rdata,
    output logic                  m0_rresponse,
    output logic                  m0_wresponse,
    input  logic [BUS_WIDTH-1:0]  m1_address,
    input  logic [BUS_WIDTH-1:0]  m1_wdata,
    input  logic [STRB_WIDTH-1:0] m1_wstrobe,
    input  logic                  m1_rrequest,
    input  logic                  m1_wrequest,
    output logic [BUS_WIDTH-1:0]  m1_rdata,
    output logic                  m1_rresponse,
    output logic                  m1_wresponse,
    output logic [BUS_WIDTH-1:0]  s_address,
    output logic [BUS_WIDTH-1:0]  s_wdata,
    output logic [STRB_WIDTH-1:0] s_wstrobe,
    output logic                  s_rrequest,
    output logic                  s_wrequest,
    input  logic [BUS_WIDTH-1:0]  s_rdata,
    input  logic                  s_rresponse,
    input  logic                  s_wresponse
);

    state_t   state;
    logic     owner;
    logic     pointer;

    bus_req_t live0, live1, sel0, sel1, s_req;
    logic     cand0, cand1;
    logic     slot_free, issue, winner, tie_to_m1, grant0, grant1;
    logic     response, response_ok;

    assign live0 = '{rrequest: m0_rrequest, wrequest: m0_wrequest,
                     address: m0_address, wdata: m0_wdata, wstrobe: m0_wstrobe};
    assign live1 = '{rrequest: m1_rrequest, wrequest: m1_wrequest,
                     address: m1_address, wdata: m1_wdata, wstrobe: m1_wstrobe};

    rvx_dbus_request_holder u_hold0 (
        .clock     (clock),
        .reset     (reset),
        .live      (live0),
        .granted   (grant0),
        .candidate (cand0),
        .selected  (sel0)
    );

    rvx_dbus_request_holder u_hold1 (
        .clock     (clock),
        .reset     (reset),
        .live      (live1),
        .granted   (grant1),
        .candidate (cand1),
        .selected  (sel1)
    );

    assign response  = s_rresponse | s_wresponse;
    // A response retires the outstanding transaction, so the slot can be reused the same cycle.
    assign slot_free = (state == STATE_IDLE) || response;
    assign issue     = !reset && slot_free && (cand0 || cand1);
    assign tie_to_m1 = (ROUND_ROBIN != 0) && (pointer == MASTER_1);
    assign winner    = (cand0 && !(cand1 && tie_to_m1)) ? MASTER_0 : MASTER_1;
    assign grant0    = issue && (winner == MASTER_0);
    assign grant1    = issue && (winner == MASTER_1);

    assign s_req      = issue ? ((winner == MASTER_1) ? sel1 : sel0) : '0;
    assign s_rrequest = s_req.rrequest;
    assign s_wrequest = s_req.wrequest;
    assign s_address  = s_req.address;
    assign s_wdata    = s_req.wdata;
    assign s_wstrobe  = s_req.wstrobe;

    // Responses arriving while idle (e.g. after a reset abandoned a transaction) are dropped.
    assign response_ok  = !reset && (state == STATE_BUSY);
    assign m0_rresponse = response_ok && (owner == MASTER_0) && s_rresponse;
    assign m0_wresponse = response_ok && (owner == MASTER_0) && s_wresponse;
    assign m1_rresponse = response_ok && (owner == MASTER_1) && s_rresponse;
    assign m1_wresponse = response_ok && (owner == MASTER_1) && s_wresponse;
    assign m0_rdata     = s_rdata;
    assign m1_rdata     = s_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= STATE_IDLE;
            owner   <= MASTER_0;
            pointer <= MASTER_0;
        end else if (issue) begin
            state <= STATE_BUSY;
            owner <= winner;
            if (ROUND_ROBIN != 0) begin
                pointer <= ~winner;
            end
        end else if (response) begin
            state <= STATE_IDLE;
        end
    end

endmodule

// File: tb/tb_rvx_dbus_arbiter.sv
module tb_rvx_dbus_arbiter;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } tb_req_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_rdata = 32'h0;
    logic        s_rresponse = 1'b0, s_wresponse = 1'b0;
    logic        f_s_rresponse = 1'b0, f_s_wresponse = 1'b0;

    tb_req_t live [2];
    bit      rst_in;

    wire [31:0] m0_address = live[0].a, m1_address = live[1].a;
    wire [31:0] m0_wdata = live[0].d, m1_wdata = live[1].d;
    wire [3:0]  m0_wstrobe = live[0].s, m1_wstrobe = live[1].s;
    wire        m0_rrequest = live[0].r, m1_rrequest = live[1].r;
    wire        m0_wrequest = live[0].w, m1_wrequest = live[1].w;

    wire [31:0] m0_rdata, m1_rdata, s_address, s_wdata;
    wire        m0_rresponse, m0_wresponse, m1_rresponse, m1_wresponse;
    wire [3:0]  s_wstrobe;
    wire        s_rrequest, s_wrequest;

    wire [31:0] f_m0_rdata, f_m1_rdata, f_s_address, f_s_wdata;
    wire        f_m0_rresponse, f_m0_wresponse, f_m1_rresponse, f_m1_wresponse;
    wire [3:0]  f_s_wstrobe;
    wire        f_s_rrequest, f_s_wrequest;

    rvx_dbus_arbiter #(.ROUND_ROBIN(1)) dut (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wstrobe(m0_wstrobe),
        .m0_rrequest(m0_rrequest), .m0_wrequest(m0_wrequest),
        .m0_rdata(m0_rdata), .m0_rresponse(m0_rresponse), .m0_wresponse(m0_wresponse),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_wstrobe(m1_wstrobe),
        .m1_rrequest(m1_rrequest), .m1_wrequest(m1_wrequest),
        .m1_rdata(m1_rdata), .m1_rresponse(m1_rresponse), .m1_wresponse(m1_wresponse),
        .s_address(s_address), .s_wdata(s_wdata), .s_wstrobe(s_wstrobe),
        .s_rrequest(s_rrequest), .s_wrequest(s_wrequest),
        .s_rdata(s_rdata), .s_rresponse(s_rresponse), .s_wresponse(s_wresponse)
    );

    // Fixed-priority instance: same masters, its own one-cycle slave.
    rvx_dbus_arbiter #(.ROUND_ROBIN(0)) dut_fixed (
        .clock(clock), .reset(reset),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wstrobe(m0_wstrobe),
        .m0_rrequest(m0_rrequest), .m0_wrequest(m0_wrequest),
        .m0_rdata(f_m0_rdata), .m0_rresponse(f_m0_rresponse), .m0_wresponse(f_m0_wresponse),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_wstrobe(m1_wstrobe),
        .m1_rrequest(m1_rrequest), .m1_wrequest(m1_wrequest),
        .m1_rdata(f_m1_rdata), .m1_rresponse(f_m1_rresponse), .m1_wresponse(f_m1_wresponse),
        .s_address(f_s_address), .s_wdata(f_s_wdata), .s_wstrobe(f_s_wstrobe),
        .s_rrequest(f_s_rrequest), .s_wrequest(f_s_wrequest),
        .s_rdata(s_rdata), .s_rresponse(f_s_rresponse), .s_wresponse(f_s_wresponse)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave model for the round-robin instance.
    int          slv_cnt = 0;
    int          slv_lat = 1;
    bit          slv_rand_lat = 0;
    bit          slv_wr = 0;
    int          slv_master = 0;
    logic [31:0] slv_data_q [$];
    // One-cycle slave for the fixed-priority instance.
    bit          f_pend_r = 0, f_pend_w = 0;

    // Reference model: who is outstanding, who is waiting, whose turn a tie is.
    bit      mdl_busy = 0;
    int      mdl_owner = 0;
    int      mdl_ptr = 0;
    bit      wait_v [2];
    tb_req_t wait_r [2];
    bit      m_out [2];
    bit      main_chk = 1;

    tb_req_t     obs_s, obs_fs;
    bit          obs_rr [2], obs_wr [2], obs_frr [2], obs_fwr [2];
    logic [31:0] obs_rd [2], obs_frd [2];
    int          grants_q [$];
    int          f_grants_q [$];

    function automatic tb_req_t mk_rd(input logic [31:0] a);
        tb_req_t q;
        q = '0;
        q.r = 1'b1;
        q.a = a;
        return q;
    endfunction

    function automatic tb_req_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        tb_req_t q;
        q = '0;
        q.w = 1'b1;
        q.a = a;
        q.d = d;
        q.s = s;
        return q;
    endfunction

    // Master m may request now if idle, or if its response lands this very cycle.
    function automatic bit can_req(input int m);
        return !m_out[m] || (slv_cnt == 1 && slv_master == m);
    endfunction

    // One bus cycle: entered at posedge+1, drives inputs, samples at negedge, returns at next posedge+1.
    task automatic run_cycle();
        tb_req_t exp_s;
        tb_req_t cand [2];
        bit      cand_v [2];
        bit      exp_rr [2];
        bit      exp_wr [2];
        bit      rsp, free;
        int      win;

        s_rresponse = 1'b0;
        s_wresponse = 1'b0;
        if (slv_cnt > 0) begin
            slv_cnt--;
            if (slv_cnt == 0) begin
                s_rdata     = (slv_data_q.size() > 0) ? slv_data_q.pop_front() : $urandom;
                s_rresponse = !slv_wr;
                s_wresponse = slv_wr;
            end
        end
        f_s_rresponse = f_pend_r;
        f_s_wresponse = f_pend_w;
        reset = rst_in;

        exp_s  = '0;
        exp_rr = '{0, 0};
        exp_wr = '{0, 0};
        if (rst_in) begin
            mdl_busy  = 0;
            mdl_owner = 0;
            mdl_ptr   = 0;
            wait_v    = '{0, 0};
            m_out     = '{0, 0};
        end else begin
            rsp = s_rresponse | s_wresponse;
            if (mdl_busy) begin
                exp_rr[mdl_owner] = s_rresponse;
                exp_wr[mdl_owner] = s_wresponse;
            end
            for (int m = 0; m < 2; m++) begin
                cand_v[m] = wait_v[m] || live[m].r || live[m].w;
                cand[m]   = wait_v[m] ? wait_r[m] : live[m];
            end
            free = !mdl_busy || rsp;
            if (free && (cand_v[0] || cand_v[1])) begin
                win = (cand_v[0] && cand_v[1]) ? mdl_ptr : (cand_v[0] ? 0 : 1);
                exp_s = cand[win];
                wait_v[win] = 0;
                if (live[1-win].r || live[1-win].w) begin
                    wait_v[1-win] = 1;
                    wait_r[1-win] = live[1-win];
                end
                mdl_busy  = 1;
                mdl_owner = win;
                mdl_ptr   = 1 - win;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (live[m].r || live[m].w) begin
                        wait_v[m] = 1;
                        wait_r[m] = live[m];
                    end
                end
                if (rsp) mdl_busy = 0;
            end
            for (int m = 0; m < 2; m++) begin
                if (exp_rr[m] || exp_wr[m]) m_out[m] = 0;
                if (live[m].r || live[m].w) m_out[m] = 1;
            end
        end

        @(negedge clock);
        obs_s  = {s_rrequest, s_wrequest, s_address, s_wdata, s_wstrobe};
        obs_fs = {f_s_rrequest, f_s_wrequest, f_s_address, f_s_wdata, f_s_wstrobe};
        obs_rr = '{m0_rresponse, m1_rresponse};
        obs_wr = '{m0_wresponse, m1_wresponse};
        obs_rd = '{m0_rdata, m1_rdata};
        obs_frr = '{f_m0_rresponse, f_m1_rresponse};
        obs_fwr = '{f_m0_wresponse, f_m1_wresponse};
        obs_frd = '{f_m0_rdata, f_m1_rdata};

        if (main_chk) begin
            n_checks++;
            if (obs_s !== exp_s)
                $display("FAIL slave_req t=%0t: got %h expected %h", $time, obs_s, exp_s);
            else n_pass++;
            n_checks++;
            if ({obs_rr[0], obs_wr[0], obs_rr[1], obs_wr[1]} !== {exp_rr[0], exp_wr[0], exp_rr[1], exp_wr[1]})
                $display("FAIL responses t=%0t: got %b%b%b%b expected %b%b%b%b", $time,
                         obs_rr[0], obs_wr[0], obs_rr[1], obs_wr[1], exp_rr[0], exp_wr[0], exp_rr[1], exp_wr[1]);
            else n_pass++;
            n_checks++;
            if (obs_rd[0] !== s_rdata || obs_rd[1] !== s_rdata)
                $display("FAIL rdata_bcast t=%0t: got %h/%h expected %h", $time, obs_rd[0], obs_rd[1], s_rdata);
            else n_pass++;
        end

        if (s_rrequest || s_wrequest) begin
            slv_cnt    = slv_rand_lat ? $urandom_range(1, 4) : slv_lat;
            slv_wr     = s_wrequest;
            slv_master = mdl_owner;
            grants_q.push_back(int'(s_address[28]));
        end
        f_pend_r = f_s_rrequest;
        f_pend_w = f_s_wrequest;
        if (f_s_rrequest || f_s_wrequest) f_grants_q.push_back(int'(f_s_address[28]));

        @(posedge clock);
        #1;
        live[0] = '0;
        live[1] = '0;
        rst_in  = 0;
    endtask

    task automatic do_reset();
        rst_in = 1;
        run_cycle();
        rst_in = 1;
        run_cycle();
        slv_cnt = 0;
        slv_data_q.delete();
    endtask

    task automatic test_reset();
        // Transaction in flight, then reset lands in the cycle its response arrives.
        slv_lat = 1;
        live[0] = mk_rd(32'h0000_0800);
        run_cycle();
        rst_in  = 1;
        live[1] = mk_rd(32'h1000_0800);
        run_cycle();
        n_checks++;
        if (obs_rr[0] !== 1'b0 || obs_s !== tb_req_t'(0))
            $display("FAIL reset_outputs: got rresp0=%b req=%h required 0", obs_rr[0], obs_s);
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_s !== tb_req_t'(0))
            $display("FAIL reset_discard: got %h required 0", obs_s);
        else n_pass++;
    endtask

    task automatic test_uncontended_read();
        do_reset();
        slv_lat = 1;
        slv_data_q.push_back(32'hDEAD_BEEF);
        live[0] = mk_rd(32'h100);
        run_cycle();
        n_checks++;
        if (obs_s.r !== 1'b1 || obs_s.a !== 32'h100)
            $display("FAIL uncontended_issue: got r=%b a=%h required r=1 a=00000100", obs_s.r, obs_s.a);
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_rr[0] !== 1'b1 || obs_rd[0] !== 32'hDEAD_BEEF || obs_rr[1] !== 1'b0)
            $display("FAIL uncontended_resp: got rr0=%b rd0=%h rr1=%b required 1 deadbeef 0",
                     obs_rr[0], obs_rd[0], obs_rr[1]);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        tb_req_t wr;
        do_reset();
        slv_lat = 1;
        wr = mk_wr(32'h20, 32'h1234_5678, 4'hF);
        live[0] = mk_rd(32'h10);
        live[1] = wr;
        run_cycle();
        n_checks++;
        if (obs_s !== mk_rd(32'h10)) $display("FAIL simul_first: got %h required %h", obs_s, mk_rd(32'h10));
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_s !== wr || obs_rr[0] !== 1'b1)
            $display("FAIL simul_second: got %h rr0=%b required %h rr0=1", obs_s, obs_rr[0], wr);
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_wr[1] !== 1'b1) $display("FAIL simul_wresp: got %b required 1", obs_wr[1]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        slv_lat = 1;
        grants_q.delete();
        for (int i = 0; i < 40 && grants_q.size() < 8; i++) begin
            for (int m = 0; m < 2; m++)
                if (can_req(m)) live[m] = mk_rd((m == 1 ? 32'h1000_0100 : 32'h0000_0100) + 32'(i * 4));
            run_cycle();
        end
        n_checks++;
        if (grants_q.size() < 8) $display("FAIL rr_timeout: got %0d grants required 8", grants_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < grants_q.size(); i++) begin
            n_checks++;
            if (grants_q[i] !== i % 2) $display("FAIL rr_grant%0d: got m%0d required m%0d", i, grants_q[i], i % 2);
            else n_pass++;
        end
    endtask

    task automatic test_fixed_priority();
        int exp_g [6] = '{0, 0, 0, 0, 0, 1};
        main_chk = 0;
        do_reset();
        f_grants_q.delete();
        live[0] = mk_rd(32'h0000_0040);
        live[1] = mk_rd(32'h1000_0040);
        run_cycle();
        for (int k = 1; k <= 4; k++) begin
            live[0] = mk_rd(32'h0000_0040 + 32'(k));
            run_cycle();
        end
        run_cycle();
        run_cycle();
        n_checks++;
        if (obs_frr[1] !== 1'b1 || obs_fwr[1] !== 1'b0 || obs_frd[1] !== s_rdata || obs_frd[0] !== s_rdata)
            $display("FAIL fixed_m1_resp: got rr=%b wr=%b rd=%h required 1 0 %h", obs_frr[1], obs_fwr[1], obs_frd[1], s_rdata);
        else n_pass++;
        n_checks++;
        if (f_grants_q.size() != 6) $display("FAIL fixed_count: got %0d grants required 6", f_grants_q.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < f_grants_q.size(); i++) begin
            n_checks++;
            if (f_grants_q[i] !== exp_g[i]) $display("FAIL fixed_grant%0d: got m%0d required m%0d", i, f_grants_q[i], exp_g[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_fs !== tb_req_t'(0)) $display("FAIL fixed_idle: got %h required 0", obs_fs);
        else n_pass++;
        main_chk = 1;
    endtask

    task automatic test_hold_busy();
        do_reset();
        slv_lat = 4;
        live[0] = mk_rd(32'h200);
        run_cycle();
        run_cycle();
        live[1] = mk_rd(32'h1000_0300);
        run_cycle();
        n_checks++;
        if (obs_s !== tb_req_t'(0)) $display("FAIL hold_c2: got %h required 0", obs_s);
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_s !== tb_req_t'(0)) $display("FAIL hold_c3: got %h required 0", obs_s);
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_s !== mk_rd(32'h1000_0300) || obs_rr[0] !== 1'b1)
            $display("FAIL hold_c4: got %h rr0=%b required %h rr0=1", obs_s, obs_rr[0], mk_rd(32'h1000_0300));
        else n_pass++;
        for (int i = 0; i < 5; i++) run_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        slv_lat = 2;
        live[0] = mk_rd(32'h400);
        run_cycle();
        rst_in  = 1;
        live[1] = mk_rd(32'h1000_0500);
        run_cycle();
        run_cycle();
        n_checks++;
        if (obs_rr[0] !== 1'b0 || obs_rr[1] !== 1'b0 || obs_s !== tb_req_t'(0))
            $display("FAIL reset_mid_drop: got rr=%b%b req=%h required 00 0", obs_rr[0], obs_rr[1], obs_s);
        else n_pass++;
        live[1] = mk_rd(32'h1000_0600);
        run_cycle();
        n_checks++;
        if (obs_s !== mk_rd(32'h1000_0600)) $display("FAIL reset_mid_issue: got %h required %h", obs_s, mk_rd(32'h1000_0600));
        else n_pass++;
        for (int i = 0; i < 3; i++) run_cycle();
    endtask

    task automatic test_byte_write();
        do_reset();
        slv_lat = 1;
        live[1] = mk_wr(32'h3, $urandom, 4'h4);
        run_cycle();
        n_checks++;
        if (obs_s.w !== 1'b1 || obs_s.s !== 4'h4 || obs_s.a !== 32'h3)
            $display("FAIL byte_write_issue: got w=%b s=%h a=%h required 1 4 00000003", obs_s.w, obs_s.s, obs_s.a);
        else n_pass++;
        run_cycle();
        n_checks++;
        if (obs_wr[1] !== 1'b1 || obs_wr[0] !== 1'b0 || obs_rr[0] !== 1'b0 || obs_rr[1] !== 1'b0)
            $display("FAIL byte_write_resp: got wr=%b%b rr=%b%b required wr1 only", obs_wr[0], obs_wr[1], obs_rr[0], obs_rr[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        do_reset();
        slv_rand_lat = 1;
        for (int i = 0; i < 400; i++) begin
            rst_in = ($urandom_range(0, 59) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!m_out[m] && $urandom_range(0, 2) == 0) begin
                    a = $urandom;
                    a[28] = (m == 1);
                    if ($urandom_range(0, 1) == 0) live[m] = mk_wr(a, $urandom, 4'($urandom));
                    else live[m] = mk_rd(a);
                end
            end
            run_cycle();
        end
        slv_rand_lat = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        live[0] = '0;
        live[1] = '0;
        rst_in  = 1;
        wait_v  = '{0, 0};
        m_out   = '{0, 0};
        @(posedge clock);
        #1;
        do_reset();
        test_reset();
        test_uncontended_read();
        test_simultaneous();
        test_round_robin();
        test_fixed_priority();
        test_hold_busy();
        test_reset_mid();
        test_byte_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
